// File: rtl/noc_packet_adapter.sv
// noc_packet_adapter
// Bridges fixed-width user data and NoC fabric packets in both directions.
// TX wraps {dest, data} into flit-formatted packets. RX strips a packet back
// to user data. Each direction has a one-entry output register and its own
// handshake.
//
// Flit layout, MSB first: valid, head, tail, vc, payload.
// The head flit payload starts with dest, then data. Data runs MSB-first
// across flit payloads. Unused payload bits and unused flits are zero.
//
// Ports:
//   clk, rst            single clock, asynchronous active-low reset
//   tx_data_in/dest_in  user word and destination node (valid/ready in)
//   tx_packet_out       formatted packet to fabric (valid/ready out)
//   rx_packet_in        packet from fabric (valid/ready in)
//   rx_data_out         extracted user data (valid/ready out)
//
// Handshake (both paths): a transfer happens on a rising edge where
// valid && ready. ready_out = ~valid_out | ready_in, so the slot can accept
// a new item in the same cycle that the old one drains. An output is held
// stable while valid_out && !ready_in.
module noc_packet_adapter #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_DATA       = 21,
  parameter int WIDTH_PKT        = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_DATA-1:0]    tx_data_in,
  input  logic [ADDRESS_WIDTH-1:0] tx_dest_in,
  input  logic                     tx_valid_in,
  output logic                     tx_ready_out,
  output logic [WIDTH_PKT-1:0]     tx_packet_out,
  output logic                     tx_valid_out,
  input  logic                     tx_ready_in,
  input  logic [WIDTH_PKT-1:0]     rx_packet_in,
  input  logic                     rx_valid_in,
  output logic                     rx_ready_out,
  output logic [WIDTH_DATA-1:0]    rx_data_out,
  output logic                     rx_valid_out,
  input  logic                     rx_ready_in
);
  localparam int FLIT_WIDTH = WIDTH_PKT / 4;
  localparam int PAYLOAD    = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;
  localparam int HD_W       = ADDRESS_WIDTH + WIDTH_DATA;
  localparam int NUM_FLITS  = (HD_W + PAYLOAD - 1) / PAYLOAD;
  localparam int STREAM_W   = NUM_FLITS * PAYLOAD;
  localparam int PAD        = STREAM_W - HD_W;

  if (NUM_FLITS > 4) begin : g_too_wide
    $error("noc_packet_adapter: dest+data needs more than 4 flits");
  end

  logic [STREAM_W-1:0]  w_tx_stream;
  logic [STREAM_W-1:0]  w_rx_stream;
  logic [WIDTH_PKT-1:0] w_tx_pkt;
  logic [WIDTH_DATA-1:0] w_rx_data;
  logic                 w_rx_keep;
  logic                 w_tx_accept;
  logic                 w_rx_accept;
  logic                 w_unused_rx;

  logic [WIDTH_PKT-1:0]  r_tx_pkt;
  logic                  r_tx_valid;
  logic [WIDTH_DATA-1:0] r_rx_data;
  logic                  r_rx_valid;

  // Left-align {dest, data} in the concatenated payload stream. The shift
  // leaves the low PAD bits zero without needing a zero-width replication.
  assign w_tx_stream = STREAM_W'({tx_dest_in, tx_data_in}) << PAD;

  for (genvar f = 0; f < 4; f++) begin : g_flit
    localparam int HI  = WIDTH_PKT - 1 - f * FLIT_WIDTH;
    localparam int SHI = STREAM_W - 1 - f * PAYLOAD;
    if (f < NUM_FLITS) begin : g_used
      assign w_tx_pkt[HI -: FLIT_WIDTH] = {1'b1, 1'(f == 0), 1'(f == NUM_FLITS - 1),
                                           {VC_ADDRESS_WIDTH{1'b0}},
                                           w_tx_stream[SHI -: PAYLOAD]};
      assign w_rx_stream[SHI -: PAYLOAD] = rx_packet_in[HI - 3 - VC_ADDRESS_WIDTH -: PAYLOAD];
    end else begin : g_unused
      assign w_tx_pkt[HI -: FLIT_WIDTH] = '0;
    end
  end

  // Dest, vc, header bits of later flits and padding are ignored on RX.
  assign w_rx_data   = w_rx_stream[STREAM_W - 1 - ADDRESS_WIDTH -: WIDTH_DATA];
  assign w_rx_keep   = rx_packet_in[WIDTH_PKT-1] & rx_packet_in[WIDTH_PKT-2];
  assign w_unused_rx = ^{rx_packet_in, w_rx_stream};

  assign tx_ready_out = ~r_tx_valid | tx_ready_in;
  assign rx_ready_out = ~r_rx_valid | rx_ready_in;
  assign w_tx_accept  = tx_valid_in & tx_ready_out;
  assign w_rx_accept  = rx_valid_in & rx_ready_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_pkt   <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_pkt   <= w_tx_pkt;
      r_tx_valid <= 1'b1;
    end else if (tx_ready_in) begin
      r_tx_valid <= 1'b0;
    end
  end

  // A malformed packet is still consumed. Its accept slot either drains
  // the current word or finds the register empty, so valid ends up low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_accept) begin
      r_rx_valid <= w_rx_keep;
      if (w_rx_keep) r_rx_data <= w_rx_data;
    end else if (rx_ready_in) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign tx_packet_out = r_tx_pkt;
  assign tx_valid_out  = r_tx_valid;
  assign rx_data_out   = r_rx_data;
  assign rx_valid_out  = r_rx_valid;

endmodule

// File: tb/tb_noc_packet_adapter.sv
// Bench for noc_packet_adapter.
// dut_a uses the default parameters. Its RX side can be driven directly or
// looped back from TX. dut_b uses WIDTH_DATA=300 (three flits) and is
// permanently looped back.
module tb_noc_packet_adapter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- dut_a (defaults) ----------------
  logic [20:0]  a_tx_data = '0;
  logic [3:0]   a_tx_dest = '0;
  logic         a_tx_valid = 1'b0;
  logic         a_tx_ready_drv = 1'b1;
  logic [511:0] a_rx_pkt_drv = '0;
  logic         a_rx_valid_drv = 1'b0;
  logic         a_rx_ready_in = 1'b1;
  logic         loop = 1'b0;

  logic         a_tx_ready_out, a_tx_valid_out, a_rx_ready_out, a_rx_valid_out;
  logic [511:0] a_tx_pkt_out;
  logic [20:0]  a_rx_data_out;
  logic         a_tx_ready_in, a_rx_valid_in;
  logic [511:0] a_rx_pkt_in;

  assign a_tx_ready_in = loop ? a_rx_ready_out : a_tx_ready_drv;
  assign a_rx_pkt_in   = loop ? a_tx_pkt_out   : a_rx_pkt_drv;
  assign a_rx_valid_in = loop ? a_tx_valid_out : a_rx_valid_drv;

  noc_packet_adapter dut_a (
    .clk(clk), .rst(rst),
    .tx_data_in(a_tx_data), .tx_dest_in(a_tx_dest), .tx_valid_in(a_tx_valid),
    .tx_ready_out(a_tx_ready_out), .tx_packet_out(a_tx_pkt_out),
    .tx_valid_out(a_tx_valid_out), .tx_ready_in(a_tx_ready_in),
    .rx_packet_in(a_rx_pkt_in), .rx_valid_in(a_rx_valid_in),
    .rx_ready_out(a_rx_ready_out), .rx_data_out(a_rx_data_out),
    .rx_valid_out(a_rx_valid_out), .rx_ready_in(a_rx_ready_in)
  );

  // ---------------- dut_b (300-bit data, looped back) ----------------
  logic [299:0] b_tx_data = '0;
  logic [3:0]   b_tx_dest = '0;
  logic         b_tx_valid = 1'b0;
  logic         b_tx_ready_out, b_tx_valid_out, b_rx_ready_out, b_rx_valid_out;
  logic [511:0] b_tx_pkt_out;
  logic [299:0] b_rx_data_out;

  noc_packet_adapter #(.WIDTH_DATA(300)) dut_b (
    .clk(clk), .rst(rst),
    .tx_data_in(b_tx_data), .tx_dest_in(b_tx_dest), .tx_valid_in(b_tx_valid),
    .tx_ready_out(b_tx_ready_out), .tx_packet_out(b_tx_pkt_out),
    .tx_valid_out(b_tx_valid_out), .tx_ready_in(b_rx_ready_out),
    .rx_packet_in(b_tx_pkt_out), .rx_valid_in(b_tx_valid_out),
    .rx_ready_out(b_rx_ready_out), .rx_data_out(b_rx_data_out),
    .rx_valid_out(b_rx_valid_out), .rx_ready_in(1'b1)
  );

  // ---------------- scoreboard ----------------
  logic [511:0] exp_tx_q[$];
  logic [20:0]  exp_rx_q[$];
  logic [511:0] exp_b_tx_q[$];
  logic [299:0] exp_b_rx_q[$];

  logic [511:0] mon_pkt;
  logic [20:0]  mon_rx;
  logic [511:0] mon_bpkt;
  logic [299:0] mon_brx;
  bit lat_arm = 1'b0;
  int first_rx_cyc = 0;
  int last_rx_cyc = 0;
  int rx_seen = 0;

  // Default-parameter packet: one flit, head and tail both set.
  function automatic logic [511:0] fmt1(input logic [3:0] d, input logic [20:0] x);
    return {3'b111, 1'b0, d, x, 483'b0};
  endfunction

  // 300-bit data: 304 bits of dest+data spread over three 124-bit payloads.
  function automatic logic [511:0] fmt3(input logic [3:0] d, input logic [299:0] x);
    return {4'b1100, d, x[299:180],
            4'b1000, x[179:56],
            4'b1010, x[55:0], 68'b0,
            128'b0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (a_tx_valid_out && a_tx_ready_in) begin
        checks++;
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL a_tx_unexpected got %0h", a_tx_pkt_out);
        end else begin
          mon_pkt = exp_tx_q.pop_front();
          if (a_tx_pkt_out !== mon_pkt) begin
            errors++;
            $display("FAIL a_tx_pkt got %0h exp %0h", a_tx_pkt_out, mon_pkt);
          end
        end
      end
      if (a_rx_valid_out && a_rx_ready_in) begin
        checks++;
        if (lat_arm) begin
          first_rx_cyc = cyc;
          lat_arm = 1'b0;
        end
        last_rx_cyc = cyc;
        rx_seen++;
        if (exp_rx_q.size() == 0) begin
          errors++;
          $display("FAIL a_rx_unexpected got %0h", a_rx_data_out);
        end else begin
          mon_rx = exp_rx_q.pop_front();
          if (a_rx_data_out !== mon_rx) begin
            errors++;
            $display("FAIL a_rx_data got %0h exp %0h", a_rx_data_out, mon_rx);
          end
        end
      end
      if (b_tx_valid_out && b_rx_ready_out) begin
        checks++;
        if (exp_b_tx_q.size() == 0) begin
          errors++;
          $display("FAIL b_tx_unexpected got %0h", b_tx_pkt_out);
        end else begin
          mon_bpkt = exp_b_tx_q.pop_front();
          if (b_tx_pkt_out !== mon_bpkt) begin
            errors++;
            $display("FAIL b_tx_pkt got %0h exp %0h", b_tx_pkt_out, mon_bpkt);
          end
        end
      end
      if (b_rx_valid_out) begin
        checks++;
        if (exp_b_rx_q.size() == 0) begin
          errors++;
          $display("FAIL b_rx_unexpected got %0h", b_rx_data_out);
        end else begin
          mon_brx = exp_b_rx_q.pop_front();
          if (b_rx_data_out !== mon_brx) begin
            errors++;
            $display("FAIL b_rx_data got %0h exp %0h", b_rx_data_out, mon_brx);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Called just after a rising edge. Holds the word until it is accepted.
  task automatic send_a(input logic [20:0] d, input logic [3:0] dst, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    a_tx_data = d;
    a_tx_dest = dst;
    a_tx_valid = 1'b1;
    while (!acc && waits < 40) begin
      @(negedge clk);
      acc = a_tx_ready_out;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL a_tx_accept_timeout got 0 exp 1");
    end else begin
      exp_tx_q.push_back(fmt1(dst, d));
      if (loop) exp_rx_q.push_back(d);
    end
    a_tx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [299:0] d, input logic [3:0] dst);
    bit acc;
    int waits;
    acc = 1'b0;
    waits = 0;
    b_tx_data = d;
    b_tx_dest = dst;
    b_tx_valid = 1'b1;
    while (!acc && waits < 40) begin
      @(negedge clk);
      acc = b_tx_ready_out;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL b_tx_accept_timeout got 0 exp 1");
    end else begin
      exp_b_tx_q.push_back(fmt3(dst, d));
      exp_b_rx_q.push_back(d);
    end
    b_tx_valid = 1'b0;
  endtask

  // Direct RX drive (loop=0). The RX register is expected to be free here.
  task automatic drive_rx(input string name, input logic [511:0] pkt, input bit keep,
                          input logic [20:0] d);
    a_rx_pkt_drv = pkt;
    a_rx_valid_drv = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 512'(a_rx_ready_out), 512'd1);
    @(posedge clk);
    #1;
    a_rx_valid_drv = 1'b0;
    if (keep) begin
      exp_rx_q.push_back(d);
    end else begin
      @(negedge clk);
      check({name, "_dropped"}, 512'(a_rx_valid_out), 512'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_tx_q.size() + exp_rx_q.size() + exp_b_tx_q.size() + exp_b_rx_q.size()) != 0
           && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain_left"},
          512'(exp_tx_q.size() + exp_rx_q.size() + exp_b_tx_q.size() + exp_b_rx_q.size()),
          512'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int n0;
    logic [511:0] p;

    // Reset state
    #3;
    check("rst_a_tx_valid", 512'(a_tx_valid_out), 512'd0);
    check("rst_a_tx_pkt", a_tx_pkt_out, 512'd0);
    check("rst_a_rx_valid", 512'(a_rx_valid_out), 512'd0);
    check("rst_a_rx_data", 512'(a_rx_data_out), 512'd0);
    check("rst_a_ready", 512'({a_tx_ready_out, a_rx_ready_out}), 512'd3);
    check("rst_b_ready", 512'({b_tx_ready_out, b_rx_ready_out}), 512'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1. TX format
    send_a(21'h1ABCDE, 4'h1, w);
    @(negedge clk);
    check("fmt_valid", 512'(a_tx_valid_out), 512'd1);
    check("fmt_hdr", 512'(a_tx_pkt_out[511:504]), 512'hE1);
    check("fmt_data", 512'(a_tx_pkt_out[503:483]), 512'h1ABCDE);
    check("fmt_rest", 512'(a_tx_pkt_out[482:0]), 512'd0);
    @(posedge clk);
    #1;
    drain("fmt");

    // 2. Loopback 0..127, one per cycle, 2-cycle latency
    loop = 1'b1;
    a_rx_ready_in = 1'b1;
    rx_seen = 0;
    lat_arm = 1'b1;
    n0 = cyc;
    for (int i = 0; i < 128; i++) send_a(21'(i), 4'h1, w);
    drain("loop");
    check("loop_count", 512'(rx_seen), 512'd128);
    check("loop_latency", 512'(first_rx_cyc - n0), 512'd2);
    check("loop_rate", 512'(last_rx_cyc - first_rx_cyc), 512'd127);
    loop = 1'b0;

    // 3. Backpressure
    a_tx_ready_drv = 1'b0;
    send_a(21'h0AAAAA, 4'h5, w);
    a_tx_data = 21'h155555;
    a_tx_dest = 4'h6;
    a_tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_low", 512'(a_tx_ready_out), 512'd0);
      check("bp_pkt_stable", a_tx_pkt_out, fmt1(4'h5, 21'h0AAAAA));
      @(posedge clk);
      #1;
    end
    a_tx_ready_drv = 1'b1;
    send_a(21'h155555, 4'h6, w);
    check("bp_resume_wait", 512'(w), 512'd0);
    send_a(21'h000001, 4'h7, w);
    check("bp_rate_c", 512'(w), 512'd0);
    send_a(21'h1FFFFF, 4'hF, w);
    check("bp_rate_d", 512'(w), 512'd0);
    drain("bp");

    // 4. Multi-flit loopback on dut_b
    send_b({10{30'h2AAA5555}}, 4'h9);
    send_b({300{1'b1}}, 4'h0);
    send_b({1'b1, 298'b0, 1'b1}, 4'hC);
    drain("multi");

    // 5. RX drop rule, then a well-formed direct packet
    p = fmt1(4'h2, 21'h12345);
    p[511] = 1'b0;
    drive_rx("drop_novalid", p, 1'b0, 21'h0);
    p = fmt1(4'h2, 21'h12345);
    p[510] = 1'b0;
    drive_rx("drop_nohead", p, 1'b0, 21'h0);
    drive_rx("rx_direct", fmt1(4'h3, 21'h0C0FFE), 1'b1, 21'h0C0FFE);
    drain("rx");

    // 6. Reset mid-stream
    a_tx_ready_drv = 1'b0;
    send_a(21'h0F0F0F, 4'h3, w);
    @(negedge clk);
    check("mid_pre_valid", 512'(a_tx_valid_out), 512'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_tx_valid", 512'(a_tx_valid_out), 512'd0);
    check("mid_tx_pkt", a_tx_pkt_out, 512'd0);
    check("mid_rx_valid", 512'(a_rx_valid_out), 512'd0);
    check("mid_ready", 512'({a_tx_ready_out, a_rx_ready_out}), 512'd3);
    exp_tx_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_tx_ready_drv = 1'b1;
    send_a(21'h15A5A5, 4'h2, w);
    check("post_rst_wait", 512'(w), 512'd0);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got timeout exp finish");
    $fatal(1, "timeout");
  end
endmodule
